hud_overlay: RTL

Output stage between the image generator and the VGA pins. It keeps a 4-digit BCD count of box bounces and draws it as seven-segment digits in a fixed screen region over the image colour. It registers colour and both syncs together, so the pins change only on clock edges and keep a fixed one-cycle alignment.

---
 rtl/hud_overlay_if.sv | 35 +++
 rtl/hud_overlay.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hud_overlay_if.sv
// hud_overlay_if: pixel-stream bundle between the video timer / image
// generator and the HUD output stage. The master side (timer + image source)
// drives position, syncs, frame counter, bounce events and image colour; the
// slave side (hud_overlay) returns the registered syncs and final colour.

interface hud_overlay_if;
    logic [9:0]  position_x;
    logic [8:0]  position_y;
    logic        visible;
    logic        hsync_in;
    logic        vsync_in;
    logic [31:0] frame;
    logic        bump;
    logic        clr;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic        hsync;
    logic        vsync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    modport master (
        output position_x, position_y, visible, hsync_in, vsync_in, frame,
               bump, clr, r_in, g_in, b_in,
        input  hsync, vsync, r, g, b
    );

    modport slave (
        input  position_x, position_y, visible, hsync_in, vsync_in, frame,
               bump, clr, r_in, g_in, b_in,
        output hsync, vsync, r, g, b
    );
endinterface

// File: rtl/hud_overlay.sv
// hud_overlay: final video output stage. Keeps a 4-digit BCD bounce counter,
// latches it once per frame so the digits never tear, draws the latched value
// as seven-segment digits over the image and registers colour plus both syncs
// so every pin carries the same single cycle of latency.
//
// Optional feature: define HUD_BLINK_EN to blink the overlay with frame[5]
// (32 frames shown, 32 frames hidden). Without it the overlay is always drawn.

module hud_overlay #(
    parameter int          HUD_X       = 8,
    parameter int          HUD_Y       = 8,
    parameter int          SEG_LEN     = 8,
    parameter int          SEG_W       = 2,
    parameter int          DIGIT_PITCH = 16,
    parameter logic [11:0] HUD_RGB     = 12'hFFF
) (
    input  logic          clk,
    input  logic          rst,
    hud_overlay_if.slave  bus
);

    localparam int CELL_W = 2 * SEG_W + SEG_LEN;
    localparam int CELL_H = 3 * SEG_W + 2 * SEG_LEN;

    // Segment bit order used throughout: {a, b, c, d, e, f, g}
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    // Which segment (if any) covers local cell coordinate (dx, dy).
    // The ranges leave the corner squares uncovered on purpose.
    function automatic logic [6:0] seg_mask(input int dx, input int dy);
        logic [6:0] m;
        logic       mid_x;
        logic       left_x;
        logic       right_x;
        logic       upper_y;
        logic       lower_y;
        mid_x   = (dx >= SEG_W) && (dx < SEG_W + SEG_LEN);
        left_x  = (dx >= 0) && (dx < SEG_W);
        right_x = (dx >= SEG_W + SEG_LEN) && (dx < 2 * SEG_W + SEG_LEN);
        upper_y = (dy >= SEG_W) && (dy < SEG_W + SEG_LEN);
        lower_y = (dy >= 2 * SEG_W + SEG_LEN) && (dy < 2 * SEG_W + 2 * SEG_LEN);
        m[6] = mid_x && (dy >= 0) && (dy < SEG_W);
        m[5] = right_x && upper_y;
        m[4] = right_x && lower_y;
        m[3] = mid_x && (dy >= 2 * SEG_W + 2 * SEG_LEN) &&
               (dy < 3 * SEG_W + 2 * SEG_LEN);
        m[2] = left_x && lower_y;
        m[1] = left_x && upper_y;
        m[0] = mid_x && (dy >= SEG_W + SEG_LEN) && (dy < 2 * SEG_W + SEG_LEN);
        return m;
    endfunction

    // Decimal increment with carry ripple; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] n;
        logic        carry;
        n     = v;
        carry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (n[k*4 +: 4] == 4'd9) begin
                    n[k*4 +: 4] = 4'd0;
                end else begin
                    n[k*4 +: 4] = n[k*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return n;
    endfunction

    logic [15:0] live_cnt;
    logic [15:0] disp_cnt;
    logic [31:0] frame_prev;
    logic [3:0]  blank;
    logic [3:0]  cell_hit;
    logic        hud_on;
    logic [11:0] colour;
    int          px_i;
    int          py_i;

    assign px_i = int'({22'd0, bus.position_x});
    assign py_i = int'({23'd0, bus.position_y});

    // Live bounce counter; clear wins over a simultaneous bump
    always_ff @(posedge clk) begin
        if (rst) begin
            live_cnt <= 16'h0000;
        end else if (bus.clr) begin
            live_cnt <= 16'h0000;
        end else if (bus.bump) begin
            live_cnt <= bcd_inc(live_cnt);
        end
    end

    // Snapshot the live count only when the frame number changes
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_cnt   <= 16'h0000;
            frame_prev <= 32'd0;
        end else if (bus.frame != frame_prev) begin
            disp_cnt   <= live_cnt;
            frame_prev <= bus.frame;
        end
    end

    // Leading-zero blanking, cell 0 holds the most significant digit
    always_comb begin
        blank    = 4'b0000;
        blank[0] = (disp_cnt[15:12] == 4'd0);
        blank[1] = blank[0] && (disp_cnt[11:8] == 4'd0);
        blank[2] = blank[1] && (disp_cnt[7:4] == 4'd0);
        blank[3] = 1'b0;
    end

    for (genvar i = 0; i < 4; i++) begin : g_cell
        localparam int CX = HUD_X + i * DIGIT_PITCH;

        logic in_cell;
        logic [6:0] lit;

        assign in_cell = (px_i >= CX) && (px_i < CX + CELL_W) &&
                         (py_i >= HUD_Y) && (py_i < HUD_Y + CELL_H);
        assign lit = seg_decode(disp_cnt[(3-i)*4 +: 4]) &
                     seg_mask(px_i - CX, py_i - HUD_Y);
        assign cell_hit[i] = in_cell && !blank[i] && (|lit);
    end

    // Choose overlay, image or black for the current pixel
    always_comb begin
`ifdef HUD_BLINK_EN
        hud_on = bus.visible && (|cell_hit) && !bus.frame[5];
`else
        hud_on = bus.visible && (|cell_hit);
`endif
        if (hud_on) begin
            colour = HUD_RGB;
        end else if (bus.visible) begin
            colour = {bus.r_in, bus.g_in, bus.b_in};
        end else begin
            colour = 12'h000;
        end
    end

    // Register colour and syncs together so they stay cycle-aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.hsync <= 1'b1;
            bus.vsync <= 1'b1;
            bus.r     <= 4'h0;
            bus.g     <= 4'h0;
            bus.b     <= 4'h0;
        end else begin
            bus.hsync <= bus.hsync_in;
            bus.vsync <= bus.vsync_in;
            bus.r     <= colour[11:8];
            bus.g     <= colour[7:4];
            bus.b     <= colour[3:0];
        end
    end

endmodule
